frame_capture: RTL and testbench
================================

// Module: frame_capture
// PURPOSE
//  Receive-side counterpart of the HDMI test-pattern path. Consumes a DVI-style pixel stream
//  (vs/hs/de + 8-bit grey), decimates the SCALE-upscaled window back to IMG_W x IMG_H and writes
//  it raster-order into a frame memory through a simple write port. Also measures incoming line
//  length and frame height so firmware can check the source format.
// PARAMETERS
//  IMG_W     225  stored image width (pixels)
//  IMG_H     225  stored image height (lines)
//  SCALE     2    source upscale factor; keep pixel/line where (pos-offset) % SCALE == 0
//  H_OFFSET  0    first captured pixel index within a DE-high line
//  V_OFFSET  0    first captured DE-line index within a frame
//  ADDR_W    16   write-address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H
// PORTS
//  clk_i          in   1       pixel clock; single clock domain
//  rst_n          in   1       asynchronous, active-low reset
//  i_vs           in   1       vertical sync, active low
//  i_hs           in   1       horizontal sync, active low (unused for counting; no checks)
//  i_de           in   1       data enable, high in active area
//  i_data         in   8       pixel grey value, valid when i_de=1
//  i_arm          in   1       1-cycle request: capture the next complete frame
//  o_busy         out  1       high from accepted arm until done/abort
//  o_done         out  1       1-cycle pulse after last memory write
//  o_err          out  1       sticky: frame ended before IMG_W*IMG_H writes; cleared by accepted arm
//  o_wr_en        out  1       memory write strobe
//  o_wr_addr      out  ADDR_W  write address, row*IMG_W+col
//  o_wr_data      out  8       write data
//  o_line_len     out  12      DE-high cycles of last completed line
//  o_frame_lines  out  12      DE lines counted in last completed frame
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, all counters 0.
//  - vs_fall = vs_q & ~i_vs (vs_q registered i_vs, resets to 1). de_fall = de_q & ~i_de.
//  - Measurement (always running, independent of state): x counts DE-high cycles, clears on
//    de_fall; on de_fall o_line_len<=x+1 (saturate at 4095), y increments; on vs_fall
//    o_frame_lines<=y, y<=0. If de_fall and vs_fall coincide, the line is counted first.
//  - FSM: IDLE -> ARMED on i_arm (o_busy=1, o_err=0, addr=0). vs_fall in the arm cycle is ignored.
//    ARMED -> CAPTURE on vs_fall. CAPTURE -> IDLE after write of addr IMG_W*IMG_H-1; o_done
//    pulses the cycle after that write, o_busy falls in the same cycle as o_done.
//    CAPTURE + vs_fall before completion: o_err<=1, addr<=0, stay CAPTURE (restart on new frame).
//  - i_arm while busy is ignored. No other source aborts a capture.
//  - Keep condition in CAPTURE: i_de=1, x in [H_OFFSET, H_OFFSET+IMG_W*SCALE),
//    (x-H_OFFSET)%SCALE==0, y in [V_OFFSET, V_OFFSET+IMG_H*SCALE), (y-V_OFFSET)%SCALE==0.
//  - Latency: kept sample registered once; o_wr_en/o_wr_data/o_wr_addr valid 1 cycle after the
//    i_data sample. o_wr_addr increments after each write; never wraps past IMG_W*IMG_H-1.
//  - Lines shorter than the window write fewer columns; the address stays at the next unwritten
//    location and is not padded. Completion then slips to later lines and o_err is set on vs_fall.
//  - Modulo via per-axis phase counters (0..SCALE-1), no dividers. Widths: x,y 12 bit.
// STRUCTURE
//  - capture_pkg: state enum {IDLE, ARMED, CAPTURE}, 640x480 timing constants for benches.
//  - Sub-module video_meas: edge detectors, x/y counters, o_line_len/o_frame_lines.
//  - frame_capture: FSM, phase counters, address generator, write register.
// TESTING
//  1. Reset, 640x480@800x525, data=(x+y)&FF, arm -> 50625 writes, mem[r*225+c]=(2c+2r)&FF, o_done once.
//  2. Same stream -> o_line_len=640, o_frame_lines=480 after first vs_fall; o_err=0.
//  3. Frame truncated to 300 DE lines then vs_fall -> o_err=1, no o_done, next full frame completes, o_done.
//  4. i_arm pulsed mid-capture -> ignored, o_err unchanged, exactly 50625 writes.
//  5. rst_n low mid-CAPTURE -> outputs 0, IDLE; no writes until new arm + vs_fall.
//  6. i_arm in same cycle as vs_fall -> capture starts at following vs_fall, not this one.

Source files
------------

// File: rtl/frame_capture_pkg.sv
// -----------------------------------------------------------------------------
// frame_capture_pkg
//   Shared types and constants for the frame capture receive path.
//   - cap_state_e : capture controller states
//   - XY_W        : width of the pixel/line position counters and measurements
//   - VGA_*       : 640x480 (800x525 total) source timing, for benches and
//                   firmware-side format checks
//   - sat_inc     : saturating increment for the position counters
// -----------------------------------------------------------------------------
package frame_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } cap_state_e;

  localparam int XY_W = 12;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_TOTAL  = 800;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_TOTAL  = 525;

  function automatic logic [XY_W-1:0] sat_inc(input logic [XY_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/frame_capture_if.sv
// -----------------------------------------------------------------------------
// frame_capture_if
//   Bundles the DVI-style pixel input, the arm/status handshake, the frame
//   memory write port and the format measurements of frame_capture.
//   master : pixel source / firmware / memory side (drives i_*, reads o_*)
//   slave  : frame_capture itself
//   Signals:
//     i_vs, i_hs      active-low syncs (i_hs carried but not interpreted)
//     i_de, i_data    data enable and 8-bit grey pixel
//     i_arm           1-cycle capture request
//     o_busy, o_done, o_err   capture status
//     o_wr_en, o_wr_addr, o_wr_data   frame memory write port
//     o_line_len, o_frame_lines       measured source format
// -----------------------------------------------------------------------------
interface frame_capture_if #(
  parameter int ADDR_W = 16
) ();

  logic              i_vs;
  logic              i_hs;
  logic              i_de;
  logic [7:0]        i_data;
  logic              i_arm;
  logic              o_busy;
  logic              o_done;
  logic              o_err;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [7:0]        o_wr_data;
  logic [11:0]       o_line_len;
  logic [11:0]       o_frame_lines;

  modport master (
    output i_vs, i_hs, i_de, i_data, i_arm,
    input  o_busy, o_done, o_err, o_wr_en, o_wr_addr, o_wr_data,
           o_line_len, o_frame_lines
  );

  modport slave (
    input  i_vs, i_hs, i_de, i_data, i_arm,
    output o_busy, o_done, o_err, o_wr_en, o_wr_addr, o_wr_data,
           o_line_len, o_frame_lines
  );

endinterface

// File: rtl/frame_capture_video_meas.sv
// -----------------------------------------------------------------------------
// video_meas
//   Free-running timing measurement of the incoming pixel stream.
//   Ports:
//     clk_i, rst_n     pixel clock, asynchronous active-low reset
//     vs, de           active-low vsync and data enable from the source
//     x, y             current pixel index within the DE line / DE line index
//                      within the frame (valid while de=1)
//     de_fall, vs_fall single-cycle edge strobes (combinational)
//     line_len         DE-high cycles of the last completed line
//     frame_lines      DE lines of the last completed frame
// -----------------------------------------------------------------------------
module video_meas
  import frame_capture_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic            vs,
  input  logic            de,
  output logic [XY_W-1:0] x,
  output logic [XY_W-1:0] y,
  output logic            de_fall,
  output logic            vs_fall,
  output logic [XY_W-1:0] line_len,
  output logic [XY_W-1:0] frame_lines
);

  logic vs_p0;
  logic de_p0;

  assign vs_fall = vs_p0 & ~vs;
  assign de_fall = de_p0 & ~de;

  // ---- stage p0: edge history, position counters, measurement latches ----
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      vs_p0       <= 1'b1;
      de_p0       <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_len    <= '0;
      frame_lines <= '0;
    end else begin
      vs_p0 <= vs;
      de_p0 <= de;

      // At the falling edge x already holds the full count of the line
      // (last pixel index + 1); sat_inc pins it at 4095 for overlong lines.
      if (de_fall) begin
        x        <= '0;
        line_len <= x;
      end else if (de) begin
        x <= sat_inc(x);
      end

      // A line ending on the same cycle as vsync still belongs to the
      // frame being closed.
      if (vs_fall) begin
        y           <= '0;
        frame_lines <= de_fall ? sat_inc(y) : y;
      end else if (de_fall) begin
        y <= sat_inc(y);
      end
    end
  end

endmodule

// File: rtl/frame_capture.sv
// -----------------------------------------------------------------------------
// frame_capture
//   Captures one SCALE-decimated IMG_W x IMG_H window of a DVI-style grey
//   pixel stream into a frame memory, raster order, after a 1-cycle arm.
//   Ports:
//     clk_i  pixel clock
//     rst_n  asynchronous active-low reset
//     bus    frame_capture_if.slave: pixel input, arm/busy/done/err,
//            memory write port (1 cycle after the kept sample),
//            line length / frame height measurements
// -----------------------------------------------------------------------------
module frame_capture
  import frame_capture_pkg::*;
#(
  parameter int IMG_W    = 225,
  parameter int IMG_H    = 225,
  parameter int SCALE    = 2,
  parameter int H_OFFSET = 0,
  parameter int V_OFFSET = 0,
  parameter int ADDR_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_n,
  frame_capture_if.slave   bus
);

  localparam int N_PIX = IMG_W * IMG_H;
  localparam int WIN_W = IMG_W * SCALE;
  localparam int WIN_H = IMG_H * SCALE;
  localparam int PH_W  = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(SCALE - 1);

  logic [XY_W-1:0] x, y;
  logic            de_fall, vs_fall;
  logic [XY_W-1:0] line_len, frame_lines;

  video_meas u_meas (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .vs          (bus.i_vs),
    .de          (bus.i_de),
    .x           (x),
    .y           (y),
    .de_fall     (de_fall),
    .vs_fall     (vs_fall),
    .line_len    (line_len),
    .frame_lines (frame_lines)
  );

  logic unused_hs;
  assign unused_hs = bus.i_hs;

  // Window test by offset subtraction: the extra MSB goes high when the
  // position is still before the offset.
  logic [XY_W:0] x_rel, y_rel;
  logic          in_x, in_y;

  assign x_rel = {1'b0, x} - (XY_W+1)'(H_OFFSET);
  assign y_rel = {1'b0, y} - (XY_W+1)'(V_OFFSET);
  assign in_x  = !x_rel[XY_W] && (x_rel < (XY_W+1)'(WIN_W));
  assign in_y  = !y_rel[XY_W] && (y_rel < (XY_W+1)'(WIN_H));

  // Phase counters track (pos - offset) % SCALE without a divider.
  logic [PH_W-1:0] ph_x, ph_y;
  logic            keep;

  assign keep = bus.i_de && in_x && in_y && (ph_x == '0) && (ph_y == '0);

  // ---- stage p0: decimation phase ----
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ph_x <= '0;
      ph_y <= '0;
    end else begin
      if (de_fall)
        ph_x <= '0;
      else if (bus.i_de && in_x)
        ph_x <= (ph_x == PH_LAST) ? '0 : ph_x + 1'b1;

      if (vs_fall)
        ph_y <= '0;
      else if (de_fall && in_y)
        ph_y <= (ph_y == PH_LAST) ? '0 : ph_y + 1'b1;
    end
  end

  cap_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr;
  logic              full;
  logic              wr_en_p1;
  logic [ADDR_W-1:0] wr_addr_p1;
  logic [7:0]        wr_data_p1;
  logic              err_q;
  logic              done_p2;

  logic busy, arm_acc, restart, wr_go, finish;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.i_arm) state_d = ARMED;
      ARMED:   if (vs_fall)   state_d = CAPTURE;
      CAPTURE: if (finish)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Once the last address has been issued (full) a late vsync no longer
  // counts as an early frame end; the pending write just drains.
  always_comb begin
    busy    = (state_q != IDLE);
    arm_acc = (state_q == IDLE) && bus.i_arm;
    restart = (state_q == CAPTURE) && vs_fall && !full;
    wr_go   = (state_q == CAPTURE) && keep && !full && !vs_fall;
    finish  = (state_q == CAPTURE) && wr_en_p1 && (wr_addr_p1 == LAST_ADDR);
  end

  // ---- stage p1: write register and address generator ----
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      addr       <= '0;
      full       <= 1'b0;
      wr_en_p1   <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
      err_q      <= 1'b0;
      done_p2    <= 1'b0;
    end else begin
      wr_en_p1 <= wr_go;
      if (wr_go) begin
        wr_addr_p1 <= addr;
        wr_data_p1 <= bus.i_data;
      end

      // ---- stage p2: completion pulse, one cycle after the last write ----
      done_p2 <= finish;

      if (arm_acc) begin
        addr  <= '0;
        full  <= 1'b0;
        err_q <= 1'b0;
      end else if (restart) begin
        addr  <= '0;
        err_q <= 1'b1;
      end else if (wr_go) begin
        if (addr == LAST_ADDR) full <= 1'b1;
        else                   addr <= addr + 1'b1;
      end
    end
  end

  assign bus.o_busy        = busy;
  assign bus.o_done        = done_p2;
  assign bus.o_err         = err_q;
  assign bus.o_wr_en       = wr_en_p1;
  assign bus.o_wr_addr     = wr_addr_p1;
  assign bus.o_wr_data     = wr_data_p1;
  assign bus.o_line_len    = line_len;
  assign bus.o_frame_lines = frame_lines;

endmodule

// File: tb/tb_frame_capture.sv
module tb_frame_capture;
  import frame_capture_pkg::*;

  localparam int IMG_W  = 8;
  localparam int IMG_H  = 6;
  localparam int SCALE  = 2;
  localparam int H_OFF  = 2;
  localparam int V_OFF  = 1;
  localparam int ADDR_W = 6;
  localparam int N_PIX  = IMG_W * IMG_H;
  localparam int ACT_W  = 20;
  localparam int ACT_H  = 14;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_i = ~clk_i;

  frame_capture_if #(.ADDR_W(ADDR_W)) bus ();

  frame_capture #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .SCALE(SCALE),
    .H_OFFSET(H_OFF), .V_OFFSET(V_OFF), .ADDR_W(ADDR_W)
  ) dut (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Write/done monitor, sampled on the inactive edge.
  logic [ADDR_W-1:0] wq_addr [$];
  logic [7:0]        wq_data [$];
  int                done_cnt = 0;

  always @(negedge clk_i) begin
    if (rst_n) begin
      if (bus.o_wr_en) begin
        wq_addr.push_back(bus.o_wr_addr);
        wq_data.push_back(bus.o_wr_data);
      end
      if (bus.o_done) begin
        done_cnt++;
        chk("busy_low_at_done", bus.o_busy, 0);
      end
    end
  end

  // Source image of the current frame, indexed [DE line][DE pixel].
  logic [7:0] pix [0:15][0:31];

  function automatic logic [7:0] pv(input int yy, input int xx);
    if (yy < 16 && xx < 32) return pix[yy][xx];
    return 8'(xx + yy);
  endfunction

  task automatic fill_pix(input bit rnd);
    for (int yy = 0; yy < 16; yy++)
      for (int xx = 0; xx < 32; xx++)
        pix[yy][xx] = rnd ? 8'($urandom) : 8'(xx + yy);
  endtask

  // Reference: stored pixel (r,c) is source pixel (V_OFF+r*SCALE, H_OFF+c*SCALE);
  // missing source pixels are skipped, so addresses are just the running count.
  logic [ADDR_W-1:0] eq_addr [$];
  logic [7:0]        eq_data [$];

  task automatic build_exp(input int nl, input int ll);
    int seq;
    eq_addr.delete();
    eq_data.delete();
    seq = 0;
    for (int r = 0; r < IMG_H; r++) begin
      int yy;
      yy = V_OFF + r * SCALE;
      if (yy < nl) begin
        for (int c = 0; c < IMG_W; c++) begin
          int xx;
          xx = H_OFF + c * SCALE;
          if (xx < ll && seq < N_PIX) begin
            eq_addr.push_back(ADDR_W'(seq));
            eq_data.push_back(pv(yy, xx));
            seq++;
          end
        end
      end
    end
  endtask

  task automatic compare_writes(input string tag, input int base);
    int n;
    n = wq_addr.size() - base;
    chk($sformatf("%s_nwrites", tag), n, eq_addr.size());
    for (int i = 0; i < n && i < eq_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wq_addr[base+i], eq_addr[i]);
      chk($sformatf("%s_data%0d", tag, i), wq_data[base+i], eq_data[i]);
    end
  endtask

  task automatic drive(input logic vs, input logic de, input logic [7:0] d, input logic arm);
    @(posedge clk_i);
    #1;
    bus.i_vs   = vs;
    bus.i_hs   = de;
    bus.i_de   = de;
    bus.i_data = d;
    bus.i_arm  = arm;
  endtask

  task automatic pulse_arm();
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},   bus.o_busy, 0);
    chk({tag, "_done"},   bus.o_done, 0);
    chk({tag, "_err"},    bus.o_err, 0);
    chk({tag, "_wr_en"},  bus.o_wr_en, 0);
    chk({tag, "_wr_addr"}, bus.o_wr_addr, 0);
    chk({tag, "_wr_data"}, bus.o_wr_data, 0);
    chk({tag, "_line_len"}, bus.o_line_len, 0);
    chk({tag, "_frame_lines"}, bus.o_frame_lines, 0);
  endtask

  // One frame: vsync pulse, then nl DE lines of ll pixels.
  // arm_line = -2 pulses arm together with the vsync edge; rst_line pulses
  // reset in the blanking before that line.
  task automatic send_frame(input int nl, input int ll, input int arm_line,
                            input int rst_line, output int wr_at_rst);
    wr_at_rst = -1;
    drive(1'b0, 1'b0, 8'h00, arm_line == -2);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (3) drive(1'b1, 1'b0, 8'h00, 1'b0);
    for (int l = 0; l < nl; l++) begin
      if (l == arm_line) drive(1'b1, 1'b0, 8'h00, 1'b1);
      if (l == rst_line) begin
        @(posedge clk_i);
        #1;
        wr_at_rst = wq_addr.size();
        rst_n = 1'b0;
        @(negedge clk_i);
        check_all_zero("midrst");
        @(posedge clk_i);
        #1;
        rst_n = 1'b1;
      end
      for (int xx = 0; xx < ll; xx++) drive(1'b1, 1'b1, pv(l, xx), 1'b0);
      repeat (6) drive(1'b1, 1'b0, 8'h00, 1'b0);
    end
    repeat (4) drive(1'b1, 1'b0, 8'h00, 1'b0);
    @(negedge clk_i);
  endtask

  int base, dbase, wr_rst, pre_exp;

  initial begin
    bus.i_vs   = 1'b1;
    bus.i_hs   = 1'b1;
    bus.i_de   = 1'b0;
    bus.i_data = 8'h00;
    bus.i_arm  = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_all_zero("reset");
    @(posedge clk_i);
    #1;
    rst_n = 1'b1;

    // Full capture of the (x+y) pattern.
    fill_pix(1'b0);
    pulse_arm();
    @(negedge clk_i);
    chk("t1_busy_after_arm", bus.o_busy, 1);
    base = wq_addr.size(); dbase = done_cnt;
    send_frame(ACT_H, ACT_W, -1, -1, wr_rst);
    build_exp(ACT_H, ACT_W);
    compare_writes("t1", base);
    chk("t1_done_once", done_cnt - dbase, 1);
    chk("t1_busy", bus.o_busy, 0);
    chk("t1_err", bus.o_err, 0);
    chk("t1_line_len", bus.o_line_len, ACT_W);
    chk("t1_frame_lines", bus.o_frame_lines, 0);

    // Same stream without arm: no writes, frame height now reported.
    base = wq_addr.size(); dbase = done_cnt;
    send_frame(ACT_H, ACT_W, -1, -1, wr_rst);
    chk("t2_nwrites", wq_addr.size() - base, 0);
    chk("t2_done", done_cnt - dbase, 0);
    chk("t2_frame_lines", bus.o_frame_lines, ACT_H);
    chk("t2_line_len", bus.o_line_len, ACT_W);
    chk("t2_err", bus.o_err, 0);

    // Truncated frame, then full frame with an ignored mid-capture arm.
    fill_pix(1'b1);
    pulse_arm();
    base = wq_addr.size(); dbase = done_cnt;
    send_frame(4, ACT_W, -1, -1, wr_rst);
    build_exp(4, ACT_W);
    compare_writes("t3_trunc", base);
    chk("t3_trunc_done", done_cnt - dbase, 0);
    chk("t3_trunc_busy", bus.o_busy, 1);
    chk("t3_trunc_err", bus.o_err, 0);
    fill_pix(1'b1);
    base = wq_addr.size(); dbase = done_cnt;
    send_frame(ACT_H, ACT_W, 5, -1, wr_rst);
    build_exp(ACT_H, ACT_W);
    compare_writes("t4_full", base);
    chk("t4_err_sticky", bus.o_err, 1);
    chk("t4_done_once", done_cnt - dbase, 1);
    chk("t4_frame_lines", bus.o_frame_lines, 4);

    // Short lines: fewer columns per line, no padding, no completion.
    fill_pix(1'b1);
    pulse_arm();
    @(negedge clk_i);
    chk("short_err_cleared", bus.o_err, 0);
    base = wq_addr.size(); dbase = done_cnt;
    send_frame(ACT_H, 10, -1, -1, wr_rst);
    build_exp(ACT_H, 10);
    compare_writes("short", base);
    chk("short_done", done_cnt - dbase, 0);
    chk("short_line_len", bus.o_line_len, 10);
    fill_pix(1'b1);
    base = wq_addr.size(); dbase = done_cnt;
    send_frame(ACT_H, ACT_W, -1, -1, wr_rst);
    build_exp(ACT_H, ACT_W);
    compare_writes("short_next", base);
    chk("short_next_err", bus.o_err, 1);
    chk("short_next_done", done_cnt - dbase, 1);

    // Reset in the middle of a capture.
    fill_pix(1'b1);
    pulse_arm();
    base = wq_addr.size();
    send_frame(ACT_H, ACT_W, -1, 6, wr_rst);
    build_exp(6, ACT_W);
    pre_exp = eq_addr.size();
    chk("t5_writes_before_rst", wr_rst - base, pre_exp);
    chk("t5_no_writes_after_rst", wq_addr.size(), wr_rst);
    chk("t5_busy", bus.o_busy, 0);
    base = wq_addr.size();
    send_frame(ACT_H, ACT_W, -1, -1, wr_rst);
    chk("t5_idle_frame_nwrites", wq_addr.size() - base, 0);

    // Arm coincident with vsync edge: this frame is skipped.
    fill_pix(1'b1);
    base = wq_addr.size(); dbase = done_cnt;
    send_frame(ACT_H, ACT_W, -2, -1, wr_rst);
    chk("t6_skip_nwrites", wq_addr.size() - base, 0);
    chk("t6_busy", bus.o_busy, 1);
    fill_pix(1'b1);
    base = wq_addr.size();
    send_frame(ACT_H, ACT_W, -1, -1, wr_rst);
    build_exp(ACT_H, ACT_W);
    compare_writes("t6_next", base);
    chk("t6_done_once", done_cnt - dbase, 1);
    chk("t6_err", bus.o_err, 0);

    // Overlong line saturates the length measurement.
    send_frame(1, 4100, -1, -1, wr_rst);
    chk("sat_line_len", bus.o_line_len, 4095);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
